// File: rtl/peg_l2_rs_rmii_rx_pkg.sv
// Shared constants and FSM state type for the RMII receive reconciliation sublayer.
package peg_l2_params;

    typedef enum logic [1:0] {
        DROP_S,
        IDLE_S,
        PRE_S,
        DATA_S
    } rx_state_e;

    localparam logic [1:0] SFD_DIBIT     = 2'b11;
    localparam logic [1:0] BAD_PRE_DIBIT = 2'b10;

    // 10 Mbps: each dibit lasts 10 reference clocks, sampled mid-dibit.
    localparam logic [3:0] OVS_DIV   = 4'd10;
    localparam logic [3:0] OVS_PHASE = 4'd4;

endpackage

// File: rtl/peg_l2_rs_rmii_rx_sampler.sv
// RMII receive input register plus the 10/100 sample-point generator.
module peg_l2_rs_rmii_rx_sampler
    import peg_l2_params::*;
(
    input  logic       rmii_ref_clk,
    input  logic       rst_n,
    input  logic       speed_100_n_10,
    input  logic [1:0] rmii_rxd,
    input  logic       rmii_crs_dv,
    input  logic       rmii_rx_er,
    output logic       sample_rdy,
    output logic [1:0] rxd,
    output logic       crs_dv,
    output logic       rx_er
);

    logic       crs_dv_d;
    logic [3:0] cnt;
    logic       line_idle;

    // Counter parks at 0 only once the line has been low for two cycles, so a
    // one-dibit carrier toggle inside a frame does not disturb the sample phase.
    assign line_idle  = (cnt == 4'd0) && !crs_dv && !crs_dv_d;
    assign sample_rdy = speed_100_n_10 || (cnt == OVS_PHASE) || line_idle;

    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            rxd      <= 2'b00;
            crs_dv   <= 1'b0;
            rx_er    <= 1'b0;
            crs_dv_d <= 1'b0;
            cnt      <= 4'd0;
        end else begin
            rxd      <= rmii_rxd;
            crs_dv   <= rmii_crs_dv;
            rx_er    <= rmii_rx_er;
            crs_dv_d <= crs_dv;
            if (line_idle)
                cnt <= 4'd0;
            else if (cnt == OVS_DIV - 4'd1)
                cnt <= 4'd0;
            else
                cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/peg_l2_rs_rmii_rx.sv
// RMII receive RS: strips preamble/SFD and packs dibits LSB-first into words for MAC RX.
// Optional macro PEG_L2_RS_RMII_RX_ALIGN_ERR_EN flags frames ending on a half byte.
module peg_l2_rs_rmii_rx
    import peg_l2_params::*;
#(
    parameter  int PKT_DATA_W = 64,
    localparam int BCNT_W     = $clog2(PKT_DATA_W / 8) + 1
) (
    input  logic                  rmii_ref_clk,
    input  logic                  rst_n,
    input  logic                  config_rs_mii_speed_100_n_10,
    input  logic [1:0]            rmii_rxd,
    input  logic                  rmii_crs_dv,
    input  logic                  rmii_rx_er,
    // pkt_valid is a one-cycle strobe with no ready: the sink must take every
    // word, and all sideband fields are qualified by (and zero without) it.
    output logic                  pkt_valid,
    output logic                  pkt_sop,
    output logic                  pkt_eop,
    output logic [PKT_DATA_W-1:0] pkt_data,
    output logic [BCNT_W-1:0]     pkt_bcnt,
    output logic                  pkt_error
);

    localparam int DIBITS = PKT_DATA_W / 2;
    localparam int KW     = $clog2(DIBITS);
    localparam int NBYTES = PKT_DATA_W / 8;

    logic                  smp, crs, er;
    logic [1:0]            rxd;
    rx_state_e             state_q, state_d;
    logic [PKT_DATA_W-1:0] asm_q, asm_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  full_q, full_d, sop_q, sop_d, err_q, err_d;
    logic                  half_byte;
    logic [BCNT_W-1:0]     part_bcnt;
    logic                  emit, emit_sop, emit_eop, emit_err;
    logic [PKT_DATA_W-1:0] emit_data;
    logic [BCNT_W-1:0]     emit_bcnt;

    peg_l2_rs_rmii_rx_sampler u_sampler (
        .rmii_ref_clk   (rmii_ref_clk),
        .rst_n          (rst_n),
        .speed_100_n_10 (config_rs_mii_speed_100_n_10),
        .rmii_rxd       (rmii_rxd),
        .rmii_crs_dv    (rmii_crs_dv),
        .rmii_rx_er     (rmii_rx_er),
        .sample_rdy     (smp),
        .rxd            (rxd),
        .crs_dv         (crs),
        .rx_er          (er)
    );

`ifdef PEG_L2_RS_RMII_RX_ALIGN_ERR_EN
    assign half_byte = k_q[1];
`else
    assign half_byte = 1'b0;
`endif

    assign part_bcnt = BCNT_W'((32'(k_q) + 32'd3) >> 2);

    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= DROP_S;
            asm_q   <= '0;
            k_q     <= '0;
            full_q  <= 1'b0;
            sop_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            k_q     <= k_d;
            full_q  <= full_d;
            sop_q   <= sop_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        asm_d     = asm_q;
        k_d       = k_q;
        full_d    = full_q;
        sop_d     = sop_q;
        err_d     = err_q;
        emit      = 1'b0;
        emit_sop  = 1'b0;
        emit_eop  = 1'b0;
        emit_err  = 1'b0;
        emit_data = '0;
        emit_bcnt = '0;
        if (smp) begin
            case (state_q)
                DROP_S: if (!crs) state_d = IDLE_S;
                IDLE_S: begin
                    if (crs) begin
                        state_d = PRE_S;
                        err_d   = 1'b0;
                    end
                end
                PRE_S: begin
                    if (!crs) begin
                        state_d = IDLE_S;
                    end else if (rxd == SFD_DIBIT) begin
                        state_d = DATA_S;
                        k_d     = '0;
                        full_d  = 1'b0;
                        sop_d   = 1'b1;
                        asm_d   = '0;
                    end else if (rxd == BAD_PRE_DIBIT) begin
                        state_d = DROP_S;
                    end
                end
                DATA_S: begin
                    if (!crs && !k_q[0]) begin
                        // End of frame on a nibble boundary; this dibit is dropped.
                        state_d = IDLE_S;
                        k_d     = '0;
                        full_d  = 1'b0;
                        asm_d   = '0;
                        if (full_q || (k_q != '0)) begin
                            emit      = 1'b1;
                            emit_sop  = sop_q;
                            emit_eop  = 1'b1;
                            emit_data = asm_q;
                            emit_bcnt = full_q ? BCNT_W'(NBYTES) : part_bcnt;
                            emit_err  = err_q | er | (!full_q && half_byte);
                        end
                    end else begin
                        if (er) err_d = 1'b1;
                        if (k_q == '0) begin
                            // First dibit of a new word releases the held one.
                            if (full_q) begin
                                emit      = 1'b1;
                                emit_sop  = sop_q;
                                emit_data = asm_q;
                                emit_bcnt = BCNT_W'(NBYTES);
                                sop_d     = 1'b0;
                                full_d    = 1'b0;
                            end
                            asm_d      = '0;
                            asm_d[1:0] = rxd;
                        end else begin
                            asm_d[2*k_q +: 2] = rxd;
                        end
                        if (k_q == KW'(DIBITS - 1)) begin
                            k_d    = '0;
                            full_d = 1'b1;
                        end else begin
                            k_d = k_q + 1'b1;
                        end
                    end
                end
                default: state_d = DROP_S;
            endcase
        end
    end

    always_ff @(posedge rmii_ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            pkt_valid <= 1'b0;
            pkt_sop   <= 1'b0;
            pkt_eop   <= 1'b0;
            pkt_data  <= '0;
            pkt_bcnt  <= '0;
            pkt_error <= 1'b0;
        end else begin
            pkt_valid <= emit;
            pkt_sop   <= emit_sop;
            pkt_eop   <= emit_eop;
            pkt_data  <= emit_data;
            pkt_bcnt  <= emit_bcnt;
            pkt_error <= emit_err;
        end
    end

endmodule

// File: tb/tb_peg_l2_rs_rmii_rx.sv
// Self-checking bench for peg_l2_rs_rmii_rx: directed table, corner sequences, random frames.
module tb_peg_l2_rs_rmii_rx;

    localparam int W  = 64;
    localparam int NB = W / 8;
    localparam int BW = $clog2(NB) + 1;
`ifdef PEG_L2_RS_RMII_RX_ALIGN_ERR_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spd = 1'b1;
    logic [1:0]    rxd = 2'b00;
    logic          crs = 1'b0;
    logic          er = 1'b0;
    logic          pkt_valid, pkt_sop, pkt_eop, pkt_error;
    logic [W-1:0]  pkt_data;
    logic [BW-1:0] pkt_bcnt;

    always #10 clk = ~clk;

    peg_l2_rs_rmii_rx #(.PKT_DATA_W(W)) dut (
        .rmii_ref_clk                 (clk),
        .rst_n                        (rst_n),
        .config_rs_mii_speed_100_n_10 (spd),
        .rmii_rxd                     (rxd),
        .rmii_crs_dv                  (crs),
        .rmii_rx_er                   (er),
        .pkt_valid                    (pkt_valid),
        .pkt_sop                      (pkt_sop),
        .pkt_eop                      (pkt_eop),
        .pkt_data                     (pkt_data),
        .pkt_bcnt                     (pkt_bcnt),
        .pkt_error                    (pkt_error)
    );

    typedef struct packed {
        logic [W-1:0]  data;
        logic          sop;
        logic          eop;
        logic [BW-1:0] bcnt;
        logic          err;
    } word_t;

    typedef struct {
        int nbytes;
        bit spd;
        bit nib;
        int er_at;
        int tog_at;
        int exp_nw;
        int exp_last_bcnt;
        bit exp_err;
    } vec_t;

    word_t      got_q[$];
    int         got_cyc[$];
    word_t      exp_q[$];
    int         exp_rel[$];
    logic [7:0] fbytes[$];
    logic [3:0] fnib;
    int         cyc = 0;
    int         side_bad = 0;
    int         n_tests = 0;
    int         n_fail = 0;

    // Clock/cycle counter and output monitor (sampled on the falling edge).
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pkt_valid) begin
            got_q.push_back({pkt_data, pkt_sop, pkt_eop, pkt_bcnt, pkt_error});
            got_cyc.push_back(cyc);
        end else if (pkt_sop || pkt_eop || pkt_error || pkt_bcnt != '0 || pkt_data != '0) begin
            side_bad++;
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] d, input logic c, input logic e, input int rep);
        rxd = d;
        crs = c;
        er  = e;
        repeat (rep) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit s, input bit nib, input int er_at, input int tog_at,
                              input bit bad_pre, input int rst_at);
        int         rep;
        logic [1:0] dq[$];
        logic [7:0] b;
        rep = s ? 1 : 10;
        spd = s;
        for (int i = 0; i < 32; i++)
            drive((i == 31) ? 2'b11 : ((bad_pre && i == 10) ? 2'b10 : 2'b01), 1'b1, 1'b0, rep);
        foreach (fbytes[k]) begin
            b = fbytes[k];
            dq.push_back(b[1:0]);
            dq.push_back(b[3:2]);
            dq.push_back(b[5:4]);
            dq.push_back(b[7:6]);
        end
        if (nib) begin
            dq.push_back(fnib[1:0]);
            dq.push_back(fnib[3:2]);
        end
        foreach (dq[j]) begin
            if (j == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk("reset_midframe_outputs",
                    {pkt_valid, pkt_sop, pkt_eop, pkt_error, pkt_bcnt, pkt_data}, '0);
                drive(dq[j], j != tog_at, j == er_at, rep);
                rst_n = 1'b1;
            end else begin
                drive(dq[j], j != tog_at, j == er_at, rep);
            end
        end
        drive(2'b00, 1'b0, 1'b0, 16 * rep);
    endtask

    // Reference: bytes are chunked into NB-byte words, first byte lowest; a word
    // is released when the first dibit of the next word (or the end) is sampled.
    task automatic build_model(input bit nib, input bit erf);
        logic [7:0] b[$];
        word_t      x;
        int         nw, total;
        b = fbytes;
        if (nib) b.push_back({4'h0, fnib});
        nw    = (b.size() + NB - 1) / NB;
        total = 4 * fbytes.size() + (nib ? 2 : 0);
        for (int w = 0; w < nw; w++) begin
            x = '0;
            for (int i = 0; i < NB; i++)
                if (w * NB + i < b.size()) x.data[8*i +: 8] = b[w*NB + i];
            x.sop  = (w == 0);
            x.eop  = (w == nw - 1);
            x.bcnt = BW'(x.eop ? b.size() - w * NB : NB);
            x.err  = x.eop && (erf || (nib && ALIGN));
            exp_q.push_back(x);
            exp_rel.push_back(x.eop ? total : (w + 1) * 32);
        end
    endtask

    task automatic check_frame(input string tag, input int rep);
        int n;
        chk($sformatf("%s_nwords", tag), got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s_w%0d", tag, i), got_q[i], exp_q[i]);
            if (i > 0)
                chk($sformatf("%s_gap%0d", tag, i), got_cyc[i] - got_cyc[i-1],
                    (exp_rel[i] - exp_rel[i-1]) * rep);
        end
        got_q.delete();
        got_cyc.delete();
        exp_q.delete();
        exp_rel.delete();
    endtask

    task automatic fill_seq(input int n);
        fbytes.delete();
        for (int i = 0; i < n; i++) fbytes.push_back(8'(i + 1));
    endtask

    vec_t tbl[9];

    initial begin
        int n, total, er_at, tog_at;
        bit s, nib;

        tbl[0] = '{8,  1'b1, 1'b0, -1, -1, 1, 8, 1'b0};
        tbl[1] = '{10, 1'b1, 1'b0, -1, -1, 2, 2, 1'b0};
        tbl[2] = '{10, 1'b0, 1'b0, -1, -1, 2, 2, 1'b0};
        tbl[3] = '{12, 1'b1, 1'b0,  9, 21, 2, 4, 1'b1};
        tbl[4] = '{8,  1'b1, 1'b1, -1, -1, 2, 1, ALIGN};
        tbl[5] = '{1,  1'b1, 1'b0, -1, -1, 1, 1, 1'b0};
        tbl[6] = '{16, 1'b1, 1'b0, -1, -1, 2, 8, 1'b0};
        tbl[7] = '{3,  1'b0, 1'b1, -1, -1, 1, 4, ALIGN};
        tbl[8] = '{24, 1'b0, 1'b0, -1, -1, 3, 8, 1'b0};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {pkt_valid, pkt_sop, pkt_eop, pkt_error, pkt_bcnt, pkt_data}, '0);
        rst_n = 1'b1;
        drive(2'b00, 1'b0, 1'b0, 5);

        // Directed table
        foreach (tbl[i]) begin
            fill_seq(tbl[i].nbytes);
            fnib = 4'h5;
            send_frame(tbl[i].spd, tbl[i].nib, tbl[i].er_at, tbl[i].tog_at, 1'b0, -1);
            chk($sformatf("tbl%0d_count", i), got_q.size(), tbl[i].exp_nw);
            if (got_q.size() == tbl[i].exp_nw) begin
                chk($sformatf("tbl%0d_last_bcnt", i), got_q[got_q.size()-1].bcnt, tbl[i].exp_last_bcnt);
                chk($sformatf("tbl%0d_last_err", i), got_q[got_q.size()-1].err, tbl[i].exp_err);
            end
            if (i == 0 && got_q.size() > 0)
                chk("single_word_data", got_q[0].data, 64'h0807060504030201);
            if (i == 1 && got_q.size() > 1)
                chk("two_word_tail_data", got_q[1].data, 64'h0000000000000A09);
            build_model(tbl[i].nib, tbl[i].er_at >= 0);
            check_frame($sformatf("tbl%0d", i), tbl[i].spd ? 1 : 10);
        end

        // Bad preamble: whole frame dropped
        fill_seq(8);
        send_frame(1'b1, 1'b0, -1, -1, 1'b1, -1);
        check_frame("bad_preamble", 1);

        // SFD followed directly by carrier loss: no output
        fill_seq(0);
        send_frame(1'b1, 1'b0, -1, -1, 1'b0, -1);
        check_frame("zero_data", 1);

        // Reset mid-frame: only the word released before reset survives
        fill_seq(20);
        send_frame(1'b1, 1'b0, -1, -1, 1'b0, 48);
        build_model(1'b0, 1'b0);
        while (exp_q.size() > 1) begin
            void'(exp_q.pop_back());
            void'(exp_rel.pop_back());
        end
        check_frame("reset_midframe", 1);

        // 8 bytes plus a trailing nibble after reset
        fill_seq(8);
        fnib = 4'hA;
        send_frame(1'b1, 1'b1, -1, -1, 1'b0, -1);
        build_model(1'b1, 1'b0);
        check_frame("post_reset_align", 1);

        // Randomised frames against the reference model
        for (int r = 0; r < 12; r++) begin
            n = $urandom_range(0, 20);
            s = ($urandom_range(0, 3) != 0);
            nib = $urandom_range(0, 1);
            fnib = 4'($urandom_range(0, 15));
            fbytes.delete();
            for (int i = 0; i < n; i++) fbytes.push_back(8'($urandom_range(0, 255)));
            total = 4 * n + (nib ? 2 : 0);
            er_at = (total > 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, total - 1) : -1;
            tog_at = (total >= 2 && $urandom_range(0, 2) == 0) ?
                     2 * $urandom_range(0, (total - 2) / 2) + 1 : -1;
            send_frame(s, nib, er_at, tog_at, 1'b0, -1);
            build_model(nib, er_at >= 0);
            check_frame($sformatf("rand%0d", r), s ? 1 : 10);
        end

        chk("sideband_idle_zero", side_bad, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
